macro_reg_bank: RTL and testbench

- Parametrised second-generation SPI-side register bank for the Decred miner top level.
- Single SPI_CLK domain; async hash-side inputs are synchronised internally; hash-side consumers resynchronise the control outputs.
- Adds over the previous bank:
  - configurable macro count;
  - sticky, maskable, write-1-to-clear interrupt status;
  - atomic snapshot read of the performance counter;
  - defined reads for unmapped addresses.

---
 rtl/macro_reg_bank_pkg.sv | 36 +++
 rtl/macro_reg_bank_if.sv | 21 ++
 rtl/macro_reg_bank_sync.sv | 24 ++
 rtl/macro_reg_bank.sv | 168 ++++++++++++++++
 tb/tb_macro_reg_bank.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/macro_reg_bank_pkg.sv
// Shared address map, CONTROL bit indices and MACRO_INFO packing
// for the Decred SPI register bank.
package decred_regs_pkg;

    localparam int ADDR_MACRO_ADDR = 'h00;
    localparam int ADDR_MACRO_DATA = 'h01;
    localparam int ADDR_MACRO_SEL  = 'h02;
    localparam int ADDR_CONTROL    = 'h03;
    localparam int ADDR_SPI_ADDR   = 'h04;
    localparam int ADDR_ID         = 'h05;
    localparam int ADDR_MACRO_INFO = 'h06;
    localparam int ADDR_PERF0      = 'h07;
    localparam int ADDR_IRQ_STATUS = 'h0B;
    localparam int ADDR_IRQ_MASK   = 'h0C;
    localparam int READBACK_BIT    = 7;

    localparam int HASHCTRL = 0;
    localparam int PERF_CLR = 1;
    localparam int PERF_RUN = 2;
    localparam int LED      = 3;
    localparam int HCLK_RST = 4;
    localparam int ID       = 5;

    // PERF_CLR is a strobe, never stored
    localparam logic [7:0] CTRL_WMASK = 8'hFD;

    function automatic logic [7:0] macro_info(
        input int unsigned n,
        input logic [3:0]  tc
    );
        logic [31:0] nv;
        nv = n;
        return {nv[3:0], tc};
    endfunction

endpackage

// File: rtl/macro_reg_bank_if.sv
// SPI-side register bus of the Decred register bank.
// The master drives address/strobes; the bank returns data_out.
interface macro_reg_bank_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [7:0]            data_in;
    logic                  read_strobe;
    logic                  write_strobe;
    logic [7:0]            data_out;

    modport master (
        output address, data_in, read_strobe, write_strobe,
        input  data_out
    );

    modport slave (
        input  address, data_in, read_strobe, write_strobe,
        output data_out
    );
endinterface

// File: rtl/macro_reg_bank_sync.sv
// Multi-flop synchroniser for async hash-side inputs,
// async active-low reset.
module reg_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/macro_reg_bank.sv
// SPI-side register bank for the Decred miner top level.
// Optional perf counter: define DECRED_REG_PERF_COUNTER_EN.
module macro_reg_bank
    import decred_regs_pkg::*;
#(
    parameter int         NUM_MACROS  = 4,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         PERF_BYTES  = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'h12
) (
    input  logic                  SPI_CLK,
    input  logic                  RST_N,
    macro_reg_bank_if.slave       bus,
    output logic                  HASH_EN,
    output logic                  LED_out,
    output logic                  hash_clock_reset,
    output logic                  ID_out,
    output logic [6:0]            spi_addr,
    output logic [5:0]            HASH_ADDR,
    output logic [7:0]            DATA_TO_HASH,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [NUM_MACROS-1:0] MACRO_WR_SELECT,
    output logic                  interrupt_out,
    input  logic [3:0]            THREAD_COUNT,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    input  logic [7:0]            DATA_FROM_HASH
);
    localparam int N = NUM_MACROS;

    logic [ADDR_WIDTH-1:0] a;
    logic [7:0]            wd;
    logic [5:0]            macro_addr;
    logic [7:0]            macro_data;
    logic [7:0]            ctrl;
    logic [6:0]            spi_addr_q;
    logic [N-1:0]          rd_sel;
    logic [N-1:0]          wr_sel;
    logic [7:0]            irq_mask;
    logic [N-1:0]          irq_status;
    logic [N-1:0]          da_s;
    logic [N-1:0]          da_prev;
    logic [N-1:0]          w1c;
    logic [7:0]            hash_s;
    logic [7:0]            rdata;
    logic [7:0]            data_out_q;
    logic                  irq_q;
    logic                  perf_sel;
    logic [1:0]            perf_k;
    logic                  unused_bits;

    assign a  = bus.address;
    assign wd = bus.data_in;

    reg_sync #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_sync_da (
        .clk(SPI_CLK), .rst_n(RST_N), .d(DATA_AVAILABLE), .q(da_s)
    );

    reg_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_dh (
        .clk(SPI_CLK), .rst_n(RST_N), .d(DATA_FROM_HASH), .q(hash_s)
    );

    function automatic logic hit(input logic [ADDR_WIDTH-1:0] x, input int c);
        return x == ADDR_WIDTH'(c);
    endfunction

    logic wr;
    assign wr = bus.write_strobe;

    assign perf_sel = (a >= ADDR_WIDTH'(ADDR_PERF0)) &&
                      (a < ADDR_WIDTH'(ADDR_PERF0 + PERF_BYTES));
    assign perf_k   = 2'(a - ADDR_WIDTH'(ADDR_PERF0));
    assign w1c      = (wr && hit(a, ADDR_IRQ_STATUS)) ? wd[N-1:0] : '0;

    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            macro_addr <= '0;
            macro_data <= '0;
            ctrl       <= '0;
            spi_addr_q <= '0;
            rd_sel     <= '0;
            wr_sel     <= '0;
            irq_mask   <= '0;
            irq_status <= '0;
            da_prev    <= '0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (wr && hit(a, ADDR_MACRO_ADDR)) macro_addr <= wd[5:0];
            if (wr && hit(a, ADDR_MACRO_DATA)) macro_data <= wd;
            if (wr && hit(a, ADDR_MACRO_SEL))  rd_sel     <= wd[N-1:0];
            if (wr && hit(a, ADDR_CONTROL))    ctrl       <= wd & CTRL_WMASK;
            if (wr && hit(a, ADDR_SPI_ADDR))   spi_addr_q <= wd[6:0];
            if (wr && hit(a, ADDR_ID))         wr_sel     <= wd[N-1:0];
            if (wr && hit(a, ADDR_IRQ_MASK))   irq_mask   <= wd;
            // new rising edges win over a same-cycle clear
            da_prev    <= da_s;
            irq_status <= (irq_status & ~w1c) | (da_s & ~da_prev);
            irq_q      <= |(irq_status & irq_mask[N-1:0]);
            if (bus.read_strobe) data_out_q <= rdata;
        end
    end

`ifdef DECRED_REG_PERF_COUNTER_EN
    localparam int PW = PERF_BYTES * 8;

    logic [PW-1:0] perf_cnt;
    logic [PW-1:0] perf_snap;
    logic          perf_clr;
    logic          perf_rd0;
    logic [7:0]    perf_byte;

    assign perf_clr  = wr && hit(a, ADDR_CONTROL) && wd[PERF_CLR];
    assign perf_rd0  = bus.read_strobe && perf_sel && (perf_k == 2'd0);
    assign perf_byte = (perf_k == 2'd0) ? perf_cnt[7:0]
                     : 8'(perf_snap >> {perf_k, 3'b000});

    always_ff @(posedge SPI_CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_cnt  <= '0;
            perf_snap <= '0;
        end else if (perf_clr) begin
            perf_cnt  <= '0;
            perf_snap <= '0;
        end else begin
            if (ctrl[PERF_RUN]) perf_cnt <= perf_cnt + PW'(1);
            if (perf_rd0)       perf_snap <= perf_cnt;
        end
    end

    assign unused_bits = ^{ctrl[7:6], ctrl[PERF_CLR]};
`else
    assign unused_bits = ^{ctrl[7:6], ctrl[PERF_CLR], ctrl[PERF_RUN],
                           perf_sel, perf_k};
`endif

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            a[READBACK_BIT]:            rdata = hash_s;
            hit(a, ADDR_MACRO_ADDR):    rdata = {2'b00, macro_addr};
            hit(a, ADDR_MACRO_DATA):    rdata = macro_data;
            hit(a, ADDR_MACRO_SEL):     rdata = 8'(da_s);
            hit(a, ADDR_CONTROL):       rdata = ctrl;
            hit(a, ADDR_SPI_ADDR):      rdata = {1'b0, spi_addr_q};
            hit(a, ADDR_ID):            rdata = ID_VALUE;
            hit(a, ADDR_MACRO_INFO):    rdata = macro_info(N, THREAD_COUNT);
`ifdef DECRED_REG_PERF_COUNTER_EN
            perf_sel:                   rdata = perf_byte;
`endif
            hit(a, ADDR_IRQ_STATUS):    rdata = 8'(irq_status);
            hit(a, ADDR_IRQ_MASK):      rdata = irq_mask;
            default:                    rdata = '0;
        endcase
    end

    assign bus.data_out      = data_out_q;
    assign HASH_EN           = ctrl[HASHCTRL];
    assign LED_out           = ctrl[LED];
    assign hash_clock_reset  = ctrl[HCLK_RST];
    assign ID_out            = ctrl[ID];
    assign spi_addr          = spi_addr_q;
    assign HASH_ADDR         = macro_addr;
    assign DATA_TO_HASH      = macro_data;
    assign MACRO_RD_SELECT   = rd_sel;
    assign MACRO_WR_SELECT   = wr_sel;
    assign interrupt_out     = irq_q;
endmodule

// File: tb/tb_macro_reg_bank.sv
// Directed self-checking bench for macro_reg_bank.
// Perf checks follow DECRED_REG_PERF_COUNTER_EN.
module tb_macro_reg_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tc = 4'd3;
    logic [3:0] da = 4'd0;
    logic [7:0] dfh = 8'd0;
    logic       hash_en, led, hclk_rst, id_o, irq;
    logic [6:0] spi_a;
    logic [5:0] h_addr;
    logic [7:0] d_to_h;
    logic [3:0] rd_sel, wr_sel;
    int n_cmp = 0;
    int n_err = 0;

    macro_reg_bank_if #(.ADDR_WIDTH(8)) bus ();

    macro_reg_bank dut (
        .SPI_CLK(clk), .RST_N(rst_n), .bus(bus),
        .HASH_EN(hash_en), .LED_out(led),
        .hash_clock_reset(hclk_rst), .ID_out(id_o),
        .spi_addr(spi_a), .HASH_ADDR(h_addr),
        .DATA_TO_HASH(d_to_h), .MACRO_RD_SELECT(rd_sel),
        .MACRO_WR_SELECT(wr_sel), .interrupt_out(irq),
        .THREAD_COUNT(tc), .DATA_AVAILABLE(da),
        .DATA_FROM_HASH(dfh)
    );

    always #5 clk = ~clk;

    // both tasks start and end on a falling edge
    task automatic wr(input logic [7:0] ad, input logic [7:0] dv);
        bus.address = ad; bus.data_in = dv; bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] ad, output logic [7:0] dv);
        bus.address = ad; bus.read_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe = 1'b0;
        dv = bus.data_out;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_cmp++;
        if ({bus.data_out, hash_en, irq, rd_sel} !== '0) begin
            n_err++; $display("FAIL reset_state: got %h want 0",
                {bus.data_out, hash_en, irq, rd_sel});
        end
        wr(8'h03, 8'h3D);
        n_cmp++;
        if ({hash_en, led, hclk_rst, id_o} !== 4'hF) begin
            n_err++; $display("FAIL ctrl_out: got %b want 1111",
                {hash_en, led, hclk_rst, id_o});
        end
        rd(8'h03, d);
        n_cmp++;
        if (d !== 8'h3D) begin
            n_err++; $display("FAIL ctrl_rd: got %h want 3d", d);
        end
        wr(8'h00, 8'h2A);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.data_out, hash_en, led, hclk_rst, id_o, spi_a, h_addr,
             d_to_h, rd_sel, wr_sel, irq} !== '0) begin
            n_err++; $display("FAIL async_reset: outputs not 0 (h_addr %h out %h)",
                h_addr, bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'h03, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL ctrl_after_rst: got %h want 00", d);
        end
    endtask

    task automatic test_map();
        logic [7:0] d;
        wr(8'h00, 8'hFF);
        n_cmp++;
        if (h_addr !== 6'h3F) begin
            n_err++; $display("FAIL hash_addr: got %h want 3f", h_addr);
        end
        rd(8'h00, d);
        n_cmp++;
        if (d !== 8'h3F) begin
            n_err++; $display("FAIL maddr_rd: got %h want 3f", d);
        end
        rd(8'h05, d);
        n_cmp++;
        if (d !== 8'h12) begin
            n_err++; $display("FAIL id_rd: got %h want 12", d);
        end
        rd(8'h06, d);
        n_cmp++;
        if (d !== 8'h43) begin
            n_err++; $display("FAIL info_rd: got %h want 43", d);
        end
        wr(8'h0D, 8'hAA);
        rd(8'h0D, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL unmapped: got %h want 00", d);
        end
        wr(8'h04, 8'hFF);
        rd(8'h04, d);
        n_cmp++;
        if (spi_a !== 7'h7F || d !== 8'h7F) begin
            n_err++; $display("FAIL spi_addr: got %h/%h want 7f/7f", spi_a, d);
        end
        wr(8'h01, 8'h5A);
        wr(8'h02, 8'h0B);
        wr(8'h05, 8'h06);
        n_cmp++;
        if ({d_to_h, rd_sel, wr_sel} !== {8'h5A, 4'hB, 4'h6}) begin
            n_err++; $display("FAIL sel_data: got %h %h %h want 5a b 6",
                d_to_h, rd_sel, wr_sel);
        end
    endtask

    task automatic test_rw_same_addr();
        logic [7:0] d;
        bus.address = 8'h01; bus.data_in = 8'hC3;
        bus.read_strobe = 1'b1; bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe = 1'b0; bus.write_strobe = 1'b0;
        n_cmp++;
        if (bus.data_out !== 8'h5A || d_to_h !== 8'hC3) begin
            n_err++; $display("FAIL rw_same: got %h/%h want 5a/c3",
                bus.data_out, d_to_h);
        end
        rd(8'h01, d);
        n_cmp++;
        if (d !== 8'hC3) begin
            n_err++; $display("FAIL rw_after: got %h want c3", d);
        end
    endtask

    task automatic test_irq_edge_mask();
        logic [7:0] d;
        da = 4'b0100;
        rd(8'h0B, d);
        rd(8'h0B, d);
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL irq_early: got %h want 00", d);
        end
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h04 || irq !== 1'b0) begin
            n_err++; $display("FAIL irq_set: got %h irq %b want 04 irq 0", d, irq);
        end
        wr(8'h0C, 8'h04);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_lat0: got %b want 0", irq);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL irq_mask_on: got %b want 1", irq);
        end
        wr(8'h0B, 8'h04);
        @(negedge clk);
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            n_err++; $display("FAIL irq_w1c: got %h irq %b want 00 irq 0", d, irq);
        end
    endtask

    task automatic test_irq_collision();
        logic [7:0] d;
        da = 4'b0101;
        @(negedge clk);
        @(negedge clk);
        wr(8'h0B, 8'h01);
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_err++; $display("FAIL irq_collide: got %h want 01", d);
        end
        wr(8'h0B, 8'h01);
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL irq_clr0: got %h want 00", d);
        end
    endtask

    task automatic test_perf();
        logic [7:0] d;
        wr(8'h03, 8'h04);
        repeat (300) @(negedge clk);
        rd(8'h07, d);
`ifdef DECRED_REG_PERF_COUNTER_EN
        n_cmp++;
        if (d !== 8'h2C) begin
            n_err++; $display("FAIL perf_b0: got %h want 2c", d);
        end
        repeat (10) @(negedge clk);
        rd(8'h08, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_err++; $display("FAIL perf_snap1: got %h want 01", d);
        end
        rd(8'h09, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL perf_snap2: got %h want 00", d);
        end
        wr(8'h03, 8'h06);
        rd(8'h08, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL perf_snapclr: got %h want 00", d);
        end
        rd(8'h07, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_err++; $display("FAIL perf_clr: got %h want 01", d);
        end
`else
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL perf_off_b0: got %h want 00", d);
        end
        wr(8'h03, 8'h06);
        rd(8'h0A, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL perf_off_b3: got %h want 00", d);
        end
`endif
        rd(8'h03, d);
        n_cmp++;
        if (d !== 8'h04) begin
            n_err++; $display("FAIL ctrl_noclr_bit: got %h want 04", d);
        end
    endtask

    task automatic test_readback();
        logic [7:0] d;
        dfh = 8'hA5;
        da  = 4'b1010;
        repeat (3) @(negedge clk);
        rd(8'h80, d);
        n_cmp++;
        if (d !== 8'hA5) begin
            n_err++; $display("FAIL readback: got %h want a5", d);
        end
        rd(8'h02, d);
        n_cmp++;
        if (d !== 8'h0A) begin
            n_err++; $display("FAIL da_level: got %h want 0a", d);
        end
        rd(8'h0B, d);
        n_cmp++;
        if (d !== 8'h0A || irq !== 1'b0) begin
            n_err++; $display("FAIL irq_multi: got %h irq %b want 0a irq 0", d, irq);
        end
    endtask

    initial begin
        bus.address = '0; bus.data_in = '0;
        bus.read_strobe = 1'b0; bus.write_strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_map();
        test_rw_same_addr();
        test_irq_edge_mask();
        test_irq_collision();
        test_perf();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
